// File: rtl/ejector_packet_scheduler_pkg.sv
// Shared definitions for the ejector packet scheduler: flit type codes,
// FSM state encodings and the flit-type field decode helper.
package ejector_packet_scheduler_pkg;

    // Flit type codes carried in data[FlitWidth +: FlitTypeWidth]
    typedef enum logic [1:0] {
        FlitHeader     = 2'b00,
        FlitPayload    = 2'b01,
        FlitTail       = 2'b10,
        FlitHeaderTail = 2'b11
    } flit_type_e;

    // Scheduler FSM encodings
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Default packed-flit geometry {vn_id, broadcast, flit_type, flit}
    localparam int unsigned DefaultFlitWidth     = 64;
    localparam int unsigned DefaultFlitTypeWidth = 2;
    localparam int unsigned DefaultDataWidth     = 70;

    // Interpret the low two bits of the extracted type field
    function automatic flit_type_e decode_flit_type(input logic [1:0] raw);
        return flit_type_e'(raw);
    endfunction

endpackage

// File: rtl/ejector_skid_buffer.sv
// Two-entry valid/ready register slice. The head entry drives the outputs
// directly, so valid_o/data_o are registered and stay stable under backpressure.
// Input ready depends only on occupancy, never on out_ready_i.
module ejector_skid_buffer #(
    parameter int unsigned DataWidth = 70
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DataWidth-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o
);

    logic [1:0]           r_count;
    logic [DataWidth-1:0] r_head;
    logic [DataWidth-1:0] r_tail;
    logic                 w_push;
    logic                 w_pop;

    assign in_ready_o  = (r_count != 2'd2);
    assign out_valid_o = (r_count != 2'd0);
    assign out_data_o  = r_head;
    assign w_push      = in_valid_i & in_ready_o;
    assign w_pop       = out_valid_o & out_ready_i;

    // Occupancy and storage update; head refills from input or from tail
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            if (w_push && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop))) begin
                r_head <= in_data_i;
            end else if (w_pop && (r_count == 2'd2)) begin
                r_head <= r_tail;
            end
            if (w_push && (r_count == 2'd1) && !w_pop) begin
                r_tail <= in_data_i;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ejector_packet_scheduler.sv
// Packet-atomic round-robin scheduler sharing one ejector sink among several
// packed-flit streams. A header locks the grant until its tail; the output is
// registered through a two-entry skid stage.
module ejector_packet_scheduler
    import ejector_packet_scheduler_pkg::*;
#(
    parameter int unsigned NumberOfRequesters     = 2,
    parameter int unsigned NetworkIfFlitWidth     = 64,
    parameter int unsigned NetworkIfFlitTypeWidth = 2,
    parameter int unsigned NetworkIfDataWidth     = 70
) (
    input  logic                                             clk_i,
    input  logic                                             rst_ni,
    input  logic [NumberOfRequesters-1:0]                    req_valid_i,
    output logic [NumberOfRequesters-1:0]                    req_ready_o,
    input  logic [NumberOfRequesters*NetworkIfDataWidth-1:0] req_data_i,
    output logic                                             valid_o,
    input  logic                                             ready_i,
    output logic [NetworkIfDataWidth-1:0]                    data_o,
    output logic [NumberOfRequesters-1:0]                    grant_o,
    output logic                                             proto_err_o
);

    localparam int unsigned N    = NumberOfRequesters;
    localparam int unsigned DW   = NetworkIfDataWidth;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    logic [0:0]                  r_state;
    logic [IdxW-1:0]             r_owner;
    logic [IdxW-1:0]             r_ptr;
    logic                        r_err;

    logic                        w_found;
    logic [IdxW-1:0]             w_winner;
    logic [IdxW-1:0]             w_sel;
    logic [IdxW-1:0]             w_ptr_next;
    logic [N-1:0]                w_grant_eff;
    logic                        w_sel_valid;
    logic [DW-1:0]               w_sel_data;
    logic [NetworkIfFlitTypeWidth-1:0] w_type_raw;
    flit_type_e                  w_type;
    logic                        w_skid_ready;
    logic                        w_xfer;

    // Round-robin pick: first valid requester at or after the pointer
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned cand;
            cand = (32'(r_ptr) + k) % N;
            if (!w_found && req_valid_i[cand]) begin
                w_found  = 1'b1;
                w_winner = IdxW'(cand);
            end
        end
    end

    // Effective grant, selected flit and its decoded type
    always_comb begin
        w_sel       = (r_state == ST_LOCKED) ? r_owner : w_winner;
        w_grant_eff = '0;
        if ((r_state == ST_LOCKED) || w_found) begin
            w_grant_eff[w_sel] = 1'b1;
        end
        w_sel_valid = |(req_valid_i & w_grant_eff);
        w_sel_data  = req_data_i[w_sel*DW +: DW];
        w_type_raw  = w_sel_data[NetworkIfFlitWidth +: NetworkIfFlitTypeWidth];
        w_type      = decode_flit_type(w_type_raw[1:0]);
        w_ptr_next  = (w_sel == LastIdx) ? '0 : w_sel + 1'b1;
    end

    // Visible owner: registered owner while locked, nothing while idle
    always_comb begin
        grant_o = '0;
        if (r_state == ST_LOCKED) begin
            grant_o[r_owner] = 1'b1;
        end
    end

    assign req_ready_o = w_grant_eff & {N{w_skid_ready}};
    assign w_xfer      = w_sel_valid & w_skid_ready;
    assign proto_err_o = r_err;

    // Lock/unlock on transferred flits; malformed sequences set the sticky error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_err   <= 1'b0;
        end else if (w_xfer) begin
            if (r_state == ST_IDLE) begin
                if (w_type == FlitHeader) begin
                    r_state <= ST_LOCKED;
                    r_owner <= w_sel;
                end else begin
                    // A packet must start with a header; treat a stray flit as single-flit
                    r_ptr <= w_ptr_next;
                    if ((w_type == FlitPayload) || (w_type == FlitTail)) begin
                        r_err <= 1'b1;
                    end
                end
            end else begin
                if ((w_type == FlitTail) || (w_type == FlitHeaderTail)) begin
                    r_state <= ST_IDLE;
                    r_ptr   <= w_ptr_next;
                end else if (w_type == FlitHeader) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    ejector_skid_buffer #(
        .DataWidth(DW)
    ) u_skid (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (w_sel_valid),
        .in_ready_o (w_skid_ready),
        .in_data_i  (w_sel_data),
        .out_valid_o(valid_o),
        .out_ready_i(ready_i),
        .out_data_o (data_o)
    );

endmodule

// File: tb/tb_ejector_packet_scheduler.sv
// Self-checking bench for ejector_packet_scheduler: directed vector table,
// hand-written stall/reset sequences and randomized traffic against a
// queue-based reference model.
module tb_ejector_packet_scheduler;
    import ejector_packet_scheduler_pkg::*;

    localparam int N  = 2;
    localparam int FW = 64;
    localparam int TW = 2;
    localparam int DW = 70;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data;
    logic            valid_o;
    logic            ready_i;
    logic [DW-1:0]   data_o;
    logic [N-1:0]    grant;
    logic            err;

    always #5 clk = ~clk;

    ejector_packet_scheduler #(
        .NumberOfRequesters    (N),
        .NetworkIfFlitWidth    (FW),
        .NetworkIfFlitTypeWidth(TW),
        .NetworkIfDataWidth    (DW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_data_i (req_data),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .grant_o    (grant),
        .proto_err_o(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk(input flit_type_e t, input logic [7:0] p);
        return {4'b0, t, 56'b0, p};
    endfunction

    // ---------------- reference model ----------------
    bit            m_locked;
    int            m_owner;
    int            m_ptr;
    bit            m_err;
    logic [DW-1:0] m_q[$];
    int            m_g;
    bit            m_xfer;
    logic [DW-1:0] m_din;
    logic [N-1:0]  m_exp_rdy;
    logic [N-1:0]  s_rdy;

    function automatic void m_reset();
        m_locked = 0;
        m_owner  = 0;
        m_ptr    = 0;
        m_err    = 0;
        m_q.delete();
    endfunction

    function automatic void m_pre();
        m_g = -1;
        if (m_locked) m_g = m_owner;
        else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (m_g < 0 && req_valid[i]) m_g = i;
            end
        end
        m_exp_rdy = '0;
        if (m_g >= 0 && m_q.size() < 2) m_exp_rdy[m_g] = 1'b1;
        m_xfer = (m_g >= 0) && req_valid[m_g] && (m_q.size() < 2);
        if (m_g >= 0) m_din = req_data[m_g*DW +: DW];
    endfunction

    function automatic void m_post(input logic rdy);
        logic [1:0] ty;
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        if (m_xfer) begin
            m_q.push_back(m_din);
            ty = m_din[FW +: TW];
            if (!m_locked) begin
                if (ty == FlitHeader) begin
                    m_locked = 1;
                    m_owner  = m_g;
                end else begin
                    if (ty == FlitPayload || ty == FlitTail) m_err = 1;
                    m_ptr = (m_g + 1) % N;
                end
            end else begin
                if (ty == FlitTail || ty == FlitHeaderTail) begin
                    m_locked = 0;
                    m_ptr    = (m_owner + 1) % N;
                end else if (ty == FlitHeader) m_err = 1;
            end
        end
    endfunction

    // One clock: drive at negedge, check ready before the edge, outputs after it
    task automatic step(input logic [N-1:0] v, input logic [DW-1:0] d0,
                        input logic [DW-1:0] d1, input logic rdy);
        logic [N-1:0] eg;
        @(negedge clk);
        req_valid = v;
        req_data  = {d1, d0};
        ready_i   = rdy;
        #1;
        m_pre();
        s_rdy = req_ready;
        chk("model_req_ready", req_ready, m_exp_rdy);
        @(posedge clk);
        #1;
        m_post(rdy);
        eg = m_locked ? (N'(1) << m_owner) : '0;
        chk("model_valid_o", valid_o, m_q.size() > 0);
        if (m_q.size() > 0) chk("model_data_o", data_o, m_q[0]);
        chk("model_grant_o", grant, eg);
        chk("model_proto_err", err, m_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_grant_o", grant, 0);
        chk("rst_proto_err", err, 0);
        m_reset();
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [N-1:0] v;
        flit_type_e   t0;
        logic [7:0]   p0;
        flit_type_e   t1;
        logic [7:0]   p1;
        logic         rdy;
        logic [N-1:0] e_rdy;
        logic         e_valid;
        logic [7:0]   e_pl;
        logic [N-1:0] e_grant;
        logic         e_err;
    } vec_t;

    vec_t vecs[14];

    // random traffic generator state
    int            g_len[N];
    int            g_pos[N];
    logic [63:0]   g_flit[N];
    logic [3:0]    g_hi[N];

    function automatic void g_new(input int r);
        g_len[r]  = $urandom_range(1, 4);
        g_pos[r]  = 0;
        g_flit[r] = {$urandom, $urandom};
        g_hi[r]   = 4'($urandom_range(0, 15));
    endfunction

    function automatic logic [DW-1:0] g_data(input int r);
        flit_type_e t;
        if (g_len[r] == 1) t = FlitHeaderTail;
        else if (g_pos[r] == 0) t = FlitHeader;
        else if (g_pos[r] == g_len[r] - 1) t = FlitTail;
        else t = FlitPayload;
        return {g_hi[r], t, g_flit[r]};
    endfunction

    initial begin
        vecs[0]  = '{2'b01, FlitHeaderTail, 8'h0A, FlitHeaderTail, 8'h00, 1, 2'b01, 1, 8'h0A, 2'b00, 0};
        vecs[1]  = '{2'b00, FlitHeaderTail, 8'h0A, FlitHeaderTail, 8'h00, 1, 2'b00, 0, 8'h00, 2'b00, 0};
        vecs[2]  = '{2'b10, FlitHeaderTail, 8'h00, FlitHeaderTail, 8'h0B, 1, 2'b10, 1, 8'h0B, 2'b00, 0};
        vecs[3]  = '{2'b11, FlitHeaderTail, 8'h10, FlitHeaderTail, 8'h11, 1, 2'b01, 1, 8'h10, 2'b00, 0};
        vecs[4]  = '{2'b11, FlitHeaderTail, 8'h12, FlitHeaderTail, 8'h11, 1, 2'b10, 1, 8'h11, 2'b00, 0};
        vecs[5]  = '{2'b11, FlitHeaderTail, 8'h12, FlitHeaderTail, 8'h13, 1, 2'b01, 1, 8'h12, 2'b00, 0};
        vecs[6]  = '{2'b11, FlitHeaderTail, 8'h14, FlitHeaderTail, 8'h13, 1, 2'b10, 1, 8'h13, 2'b00, 0};
        vecs[7]  = '{2'b11, FlitHeader,     8'h20, FlitHeader,     8'h30, 1, 2'b01, 1, 8'h20, 2'b01, 0};
        vecs[8]  = '{2'b11, FlitPayload,    8'h21, FlitHeader,     8'h30, 1, 2'b01, 1, 8'h21, 2'b01, 0};
        vecs[9]  = '{2'b11, FlitTail,       8'h22, FlitHeader,     8'h30, 1, 2'b01, 1, 8'h22, 2'b00, 0};
        vecs[10] = '{2'b10, FlitTail,       8'h22, FlitHeader,     8'h30, 1, 2'b10, 1, 8'h30, 2'b10, 0};
        vecs[11] = '{2'b10, FlitTail,       8'h22, FlitTail,       8'h31, 1, 2'b10, 1, 8'h31, 2'b00, 0};
        vecs[12] = '{2'b01, FlitPayload,    8'h40, FlitTail,       8'h31, 1, 2'b01, 1, 8'h40, 2'b00, 1};
        vecs[13] = '{2'b00, FlitPayload,    8'h40, FlitTail,       8'h31, 1, 2'b00, 0, 8'h00, 2'b00, 1};

        req_valid = '0;
        req_data  = '0;
        ready_i   = 1'b1;
        rst_n     = 1'b0;
        m_reset();
        #3;
        chk("reset_valid_o", valid_o, 0);
        chk("reset_data_o", data_o, 0);
        chk("reset_grant_o", grant, 0);
        chk("reset_proto_err", err, 0);
        chk("reset_req_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // table: single flit, alternation, packet atomicity, stray payload
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].v, mk(vecs[i].t0, vecs[i].p0), mk(vecs[i].t1, vecs[i].p1), vecs[i].rdy);
            chk($sformatf("vec%0d_req_ready", i), s_rdy, vecs[i].e_rdy);
            chk($sformatf("vec%0d_valid_o", i), valid_o, vecs[i].e_valid);
            if (vecs[i].e_valid) chk($sformatf("vec%0d_data_o", i), data_o[7:0], vecs[i].e_pl);
            chk($sformatf("vec%0d_grant_o", i), grant, vecs[i].e_grant);
            chk($sformatf("vec%0d_proto_err", i), err, vecs[i].e_err);
        end

        // sticky error survives idle cycles, clears on reset
        step(2'b00, '0, '0, 1);
        chk("err_sticky", err, 1);
        do_reset();

        // stall mid-packet on req1: output held, ready drops once skid is full
        step(2'b10, '0, mk(FlitHeader, 8'h50), 1);
        chk("stall_grant", grant, 2'b10);
        step(2'b10, '0, mk(FlitPayload, 8'h51), 0);
        chk("stall_data0", data_o, mk(FlitHeader, 8'h50));
        for (int i = 1; i < 5; i++) begin
            step(2'b10, '0, mk(FlitPayload, 8'h52), 0);
            chk($sformatf("stall%0d_req_ready", i), s_rdy, 2'b00);
            chk($sformatf("stall%0d_valid_o", i), valid_o, 1);
            chk($sformatf("stall%0d_data_o", i), data_o, mk(FlitHeader, 8'h50));
        end
        step(2'b10, '0, mk(FlitPayload, 8'h52), 1);
        chk("drain_data_o", data_o, mk(FlitPayload, 8'h51));
        step(2'b10, '0, mk(FlitPayload, 8'h52), 1);
        chk("drain2_data_o", data_o, mk(FlitPayload, 8'h52));
        step(2'b10, '0, mk(FlitTail, 8'h53), 1);
        chk("drain3_data_o", data_o, mk(FlitTail, 8'h53));
        step(2'b00, '0, '0, 1);
        chk("drain_empty", valid_o, 0);

        // async reset mid-packet, then a fresh packet from req1
        step(2'b01, mk(FlitHeader, 8'h60), '0, 1);
        step(2'b01, mk(FlitPayload, 8'h61), '0, 1);
        chk("pre_reset_grant", grant, 2'b01);
        do_reset();
        step(2'b10, '0, mk(FlitHeader, 8'h70), 1);
        chk("post_reset_req_ready", s_rdy, 2'b10);
        chk("post_reset_data_o", data_o, mk(FlitHeader, 8'h70));
        chk("post_reset_grant", grant, 2'b10);
        step(2'b10, '0, mk(FlitTail, 8'h71), 1);
        step(2'b00, '0, '0, 1);

        // randomized well-formed traffic against the model
        do_reset();
        for (int r = 0; r < N; r++) g_new(r);
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] v;
            for (int r = 0; r < N; r++) v[r] = ($urandom_range(0, 9) < 7);
            step(v, g_data(0), g_data(1), ($urandom_range(0, 3) != 0));
            if (m_xfer) begin
                g_pos[m_g]++;
                if (g_pos[m_g] == g_len[m_g]) g_new(m_g);
                else g_flit[m_g] = {$urandom, $urandom};
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
